// File: rtl/rtc_pkg.sv
// Shared constants, field codes and wrap-step helper for the RTC timekeeper.
package rtc_pkg;

    localparam int unsigned BCD_W   = 4;
    localparam int unsigned FIELD_W = 7;
    localparam int unsigned SEL_W   = 3;
    localparam int unsigned TIME_W  = 6 * BCD_W;

    typedef enum logic [SEL_W-1:0] {
        FIELD_SEC     = 3'd0,
        FIELD_MIN     = 3'd1,
        FIELD_HR      = 3'd2,
        FIELD_ALM_MIN = 3'd3,
        FIELD_ALM_HR  = 3'd4
    } field_sel_e;

    // One edit step: +1 wraps max->0, -1 wraps 0->max, both or neither hold.
    function automatic logic [FIELD_W-1:0] wrap_step(
        input logic [FIELD_W-1:0] val,
        input logic [FIELD_W-1:0] max_val,
        input logic               inc,
        input logic               dec
    );
        logic [FIELD_W-1:0] res;
        res = val;
        if (inc && !dec) begin
            res = (val >= max_val) ? '0 : val + FIELD_W'(1);
        end else if (dec && !inc) begin
            res = (val == '0) ? max_val : val - FIELD_W'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/bin2bcd99.sv
// Combinational 7-bit binary to two BCD digits; tens digit saturates at 9.
module bin2bcd99
    import rtc_pkg::*;
(
    input  logic [FIELD_W-1:0] bin,
    output logic [BCD_W-1:0]   tens,
    output logic [BCD_W-1:0]   ones
);

    logic [FIELD_W-1:0] tens_raw;

    always_comb begin
        tens_raw = bin / FIELD_W'(10);
        tens     = (tens_raw > FIELD_W'(9)) ? BCD_W'(9) : BCD_W'(tens_raw);
        ones     = BCD_W'(bin % FIELD_W'(10));
    end

endmodule

// File: rtl/rtc_timekeeper.sv
// Time-of-day counter with field editing and 12/24 h BCD display.
// Alarm compiled in with RTC_TIMEKEEPER_ALARM_EN.
module rtc_timekeeper
    import rtc_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 1,
    parameter int unsigned SEC_MAX   = 59,
    parameter int unsigned HOUR_MAX  = 23,
    parameter int unsigned ALARM_LEN = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_in,
    input  logic              mode12,
    input  logic              set_mode,
    input  logic [SEL_W-1:0]  field_sel,
    input  logic              inc_btn,
    input  logic              dec_btn,
    output logic [TIME_W-1:0] time_bcd,
    output logic              pm,
    output logic              sec_strobe,
    output logic              day_wrap,
    output logic              alarm_out
);

    localparam int unsigned        PRESC_W    = 10;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [FIELD_W-1:0] SEC_LIM    = FIELD_W'(SEC_MAX);
    localparam logic [FIELD_W-1:0] HR_LIM     = FIELD_W'(HOUR_MAX);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [FIELD_W-1:0] sec_q, sec_d, min_q, min_d, hr_q, hr_d;
    logic               sec_strobe_q, sec_strobe_d;
    logic               day_wrap_q, day_wrap_d;
    logic [TIME_W-1:0]  time_bcd_q, time_bcd_d;
    logic               pm_q, pm_d;
    logic               sec_evt_c;
    logic [FIELD_W-1:0] disp_hr_c;
    logic [BCD_W-1:0]   hr_t, hr_o, min_t, min_o, sec_t, sec_o;

    // Prescaler, carry chain and field edits
    always_comb begin
        presc_d      = presc_q;
        sec_d        = sec_q;
        min_d        = min_q;
        hr_d         = hr_q;
        sec_evt_c    = 1'b0;
        sec_strobe_d = 1'b0;
        day_wrap_d   = 1'b0;

        if (set_mode) begin
            presc_d = '0;
            case (field_sel)
                FIELD_SEC: sec_d = wrap_step(sec_q, SEC_LIM, inc_btn, dec_btn);
                FIELD_MIN: min_d = wrap_step(min_q, SEC_LIM, inc_btn, dec_btn);
                FIELD_HR:  hr_d  = wrap_step(hr_q, HR_LIM, inc_btn, dec_btn);
                default: ;
            endcase
        end else if (tick_in) begin
            if (presc_q == PRESC_LAST) begin
                presc_d   = '0;
                sec_evt_c = 1'b1;
            end else begin
                presc_d = presc_q + PRESC_W'(1);
            end
        end

        if (sec_evt_c) begin
            sec_strobe_d = 1'b1;
            if (sec_q == SEC_LIM) begin
                sec_d = '0;
                if (min_q == SEC_LIM) begin
                    min_d = '0;
                    if (hr_q == HR_LIM) begin
                        hr_d       = '0;
                        day_wrap_d = 1'b1;
                    end else begin
                        hr_d = hr_q + FIELD_W'(1);
                    end
                end else begin
                    min_d = min_q + FIELD_W'(1);
                end
            end else begin
                sec_d = sec_q + FIELD_W'(1);
            end
        end
    end

    // 12 h remap: 0 shows as 12, 13.. show as hr-12
    always_comb begin
        disp_hr_c = hr_q;
        if (mode12) begin
            if (hr_q == '0) begin
                disp_hr_c = FIELD_W'(12);
            end else if (hr_q > FIELD_W'(12)) begin
                disp_hr_c = hr_q - FIELD_W'(12);
            end
        end
        pm_d       = mode12 && (hr_q >= FIELD_W'(12));
        time_bcd_d = {hr_t, hr_o, min_t, min_o, sec_t, sec_o};
    end

    bin2bcd99 u_bcd_hr  (.bin(disp_hr_c), .tens(hr_t),  .ones(hr_o));
    bin2bcd99 u_bcd_min (.bin(min_q),     .tens(min_t), .ones(min_o));
    bin2bcd99 u_bcd_sec (.bin(sec_q),     .tens(sec_t), .ones(sec_o));

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q      <= '0;
            sec_q        <= '0;
            min_q        <= '0;
            hr_q         <= '0;
            sec_strobe_q <= 1'b0;
            day_wrap_q   <= 1'b0;
            time_bcd_q   <= '0;
            pm_q         <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            sec_q        <= sec_d;
            min_q        <= min_d;
            hr_q         <= hr_d;
            sec_strobe_q <= sec_strobe_d;
            day_wrap_q   <= day_wrap_d;
            time_bcd_q   <= time_bcd_d;
            pm_q         <= pm_d;
        end
    end

    assign time_bcd   = time_bcd_q;
    assign pm         = pm_q;
    assign sec_strobe = sec_strobe_q;
    assign day_wrap   = day_wrap_q;

`ifdef RTC_TIMEKEEPER_ALARM_EN
    localparam int unsigned ALM_CNT_W = 10;

    logic [FIELD_W-1:0]   alm_min_q, alm_min_d, alm_hr_q, alm_hr_d;
    logic [ALM_CNT_W-1:0] alm_cnt_q, alm_cnt_d;
    logic                 alarm_out_q, alarm_out_d;

    // Alarm edits, match on the post-carry time, and seconds countdown
    always_comb begin
        alm_min_d   = alm_min_q;
        alm_hr_d    = alm_hr_q;
        alm_cnt_d   = alm_cnt_q;
        alarm_out_d = alarm_out_q;

        if (set_mode) begin
            case (field_sel)
                FIELD_ALM_MIN: alm_min_d = wrap_step(alm_min_q, SEC_LIM, inc_btn, dec_btn);
                FIELD_ALM_HR:  alm_hr_d  = wrap_step(alm_hr_q, HR_LIM, inc_btn, dec_btn);
                default: ;
            endcase
        end

        if (set_mode || inc_btn || dec_btn) begin
            alarm_out_d = 1'b0;
            alm_cnt_d   = '0;
        end else if (sec_evt_c && sec_d == '0 && min_d == alm_min_q && hr_d == alm_hr_q) begin
            alarm_out_d = 1'b1;
            alm_cnt_d   = ALM_CNT_W'(ALARM_LEN);
        end else if (sec_evt_c && alarm_out_q) begin
            if (alm_cnt_q <= ALM_CNT_W'(1)) begin
                alarm_out_d = 1'b0;
                alm_cnt_d   = '0;
            end else begin
                alm_cnt_d = alm_cnt_q - ALM_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alm_min_q   <= '0;
            alm_hr_q    <= '0;
            alm_cnt_q   <= '0;
            alarm_out_q <= 1'b0;
        end else begin
            alm_min_q   <= alm_min_d;
            alm_hr_q    <= alm_hr_d;
            alm_cnt_q   <= alm_cnt_d;
            alarm_out_q <= alarm_out_d;
        end
    end

    assign alarm_out = alarm_out_q;
`else
    assign alarm_out = 1'b0;
`endif

endmodule
